uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it.
// Frames are: start bit, DATA_W data bits (LSB first), an optional parity bit,
// and one or two stop bits. One bit period lasts 16*(br_div+1) clock cycles.
// The divisor, the stop-bit count and the data word are captured when an entry
// is popped, so later changes to the inputs do not affect the frame in flight.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PARITY = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [7:0]                   br_div,
    input  logic                         stop,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    // FIFO storage and status
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic [CW-1:0]     w_count_next;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;

    // Transmit engine
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [7:0]        r_div_lat;
    logic              r_stop_lat;
    logic [3:0]        r_os_cnt;
    logic [7:0]        r_div_cnt;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_stop_cnt;
    logic              r_tx;
    logic              w_bit_end;
    logic              w_frame_end;
    logic              w_tx_line;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_push      = wr_en & ~r_full;
    assign w_bit_end   = (r_os_cnt == 4'hF) && (r_div_cnt == r_div_lat);
    assign w_frame_end = (r_state == STOP) && w_bit_end && (r_stop_cnt == r_stop_lat);
    // A pop may happen from IDLE or in the final cycle of a frame (no idle gap).
    assign w_pop       = ((r_state == IDLE) || w_frame_end) && en && ~r_empty;

    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;
    assign tx    = r_tx;

    // Next FIFO occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // FIFO storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_next = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end && (r_bit_cnt == BW'(DATA_W-1))) begin
                    w_next = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (w_bit_end) begin
                    w_next = STOP;
                end
            end
            STOP: begin
                if (w_frame_end) begin
                    w_next = w_pop ? START : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs: line level for the current state and the busy flag
    always_comb begin
        w_tx_line = 1'b1;
        busy      = 1'b1;
        case (r_state)
            IDLE:    busy      = 1'b0;
            START:   w_tx_line = 1'b0;
            DATA:    w_tx_line = r_shift[0];
            PAR:     w_tx_line = r_par;
            default: w_tx_line = 1'b1;
        endcase
    end

    // Bit timing counters, frame latches and the registered serial output.
    // Counters restart on every bit boundary, which covers every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_cnt   <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_div_lat  <= '0;
            r_stop_lat <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_line;

            if ((r_state == IDLE) || w_bit_end) begin
                r_os_cnt  <= '0;
                r_div_cnt <= '0;
            end else if (r_os_cnt == 4'hF) begin
                r_os_cnt  <= '0;
                r_div_cnt <= r_div_cnt + 8'd1;
            end else begin
                r_os_cnt <= r_os_cnt + 4'd1;
            end

            if (w_pop) begin
                r_shift    <= w_head;
                r_par      <= (^w_head) ^ (PARITY == 2);
                r_div_lat  <= br_div;
                r_stop_lat <= stop;
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
            end else if (w_bit_end) begin
                if (r_state == DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
                if (r_state == STOP) begin
                    r_stop_cnt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: three instances (no/even/odd parity, different
// depths) share all inputs. Pushes feed per-instance expected-frame queues;
// a line monitor per instance pops an entry at every start bit and compares
// the whole serial waveform cycle by cycle against the frame format.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] br_div;
    logic       stop;
    logic       wr_en;
    logic [7:0] wr_data;

    logic       full0, empty0, busy0, tx0;
    logic       full1, empty1, busy1, tx1;
    logic       full2, empty2, busy2, tx2;
    logic [2:0] cnt0;
    logic [4:0] cnt1;
    logic [3:0] cnt2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         mcnt[3];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .PARITY(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .br_div(br_div), .stop(stop),
        .wr_en(wr_en), .wr_data(wr_data), .full(full0), .empty(empty0),
        .count(cnt0), .busy(busy0), .tx(tx0));

    uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .PARITY(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .br_div(br_div), .stop(stop),
        .wr_en(wr_en), .wr_data(wr_data), .full(full1), .empty(empty1),
        .count(cnt1), .busy(busy1), .tx(tx1));

    uart_tx_fifo #(.DATA_W(8), .DEPTH(8), .PARITY(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .br_div(br_div), .stop(stop),
        .wr_en(wr_en), .wr_data(wr_data), .full(full2), .empty(empty2),
        .count(cnt2), .busy(busy2), .tx(tx2));

    function automatic int depth_of(input int g);
        case (g)
            0:       return 4;
            1:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic logic get_tx(input int g);
        case (g)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_busy(input int g);
        case (g)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_full(input int g);
        case (g)
            0:       return full0;
            1:       return full1;
            default: return full2;
        endcase
    endfunction

    function automatic logic get_empty(input int g);
        case (g)
            0:       return empty0;
            1:       return empty1;
            default: return empty2;
        endcase
    endfunction

    function automatic int get_cnt(input int g);
        case (g)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int q_size(input int g);
        case (g)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] q_pop(input int g);
        case (g)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void q_push(input int g, input logic [7:0] d);
        case (g)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endfunction

    // Line level expected at cycle t of a frame with bit period per
    function automatic logic exp_bit(input logic [7:0] d, input int t, input int per, input int par);
        int b;
        b = t / per;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par != 0 && b == 9) return (par == 1) ? (^d) : ~(^d);
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        for (int g = 0; g < 3; g++) begin
            if (mcnt[g] < depth_of(g)) begin
                mcnt[g]++;
                q_push(g, d);
            end
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_status(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_count[%0d]", tag, g), get_cnt(g), mcnt[g]);
            chk($sformatf("%s_full[%0d]", tag, g), int'(get_full(g)), int'(mcnt[g] == depth_of(g)));
            chk($sformatf("%s_empty[%0d]", tag, g), int'(get_empty(g)), int'(mcnt[g] == 0));
        end
    endtask

    function automatic logic all_idle(input logic need_empty);
        logic r;
        r = !busy0 && !busy1 && !busy2;
        if (need_empty) r = r && empty0 && empty1 && empty2;
        return r;
    endfunction

    task automatic drain(input string tag, input logic need_empty, input int bound);
        int n;
        n = 0;
        while (!all_idle(need_empty) && n < bound) begin
            tick();
            n++;
        end
        chk($sformatf("%s_drain_done", tag), int'(all_idle(need_empty)), 1);
        if (need_empty) begin
            for (int g = 0; g < 3; g++) mcnt[g] = 0;
        end
        repeat (3) tick();
    endtask

    // Push one word to an idle, empty transmitter and measure busy duration
    task automatic frame_len(input logic [7:0] d, input logic stopv);
        int len[3];
        int n;
        stop   = stopv;
        br_div = 8'd0;
        en     = 1'b1;
        push(d);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("push_nopop_count[%0d]", g), get_cnt(g), 1);
            chk($sformatf("push_nopop_busy[%0d]", g), int'(get_busy(g)), 0);
        end
        tick();
        for (int g = 0; g < 3; g++) begin
            mcnt[g] = 0;
            chk($sformatf("pop_edge_busy[%0d]", g), int'(get_busy(g)), 1);
            chk($sformatf("pop_edge_tx_high[%0d]", g), int'(get_tx(g)), 1);
            chk($sformatf("pop_edge_empty[%0d]", g), int'(get_empty(g)), 1);
            len[g] = -1;
        end
        tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("start_tx_low[%0d]", g), int'(get_tx(g)), 0);
        end
        n = 1;
        while ((len[0] < 0 || len[1] < 0 || len[2] < 0) && n < 2000) begin
            for (int g = 0; g < 3; g++) begin
                if (len[g] < 0 && !get_busy(g)) len[g] = n;
            end
            tick();
            n++;
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("busy_len_stop%0d[%0d]", stopv, g), len[g],
                16 * (1 + 8 + ((g != 0) ? 1 : 0) + (stopv ? 2 : 1)));
        end
        repeat (3) tick();
    endtask

    // Serial line monitor: pops the expected word at each start bit
    task automatic run_mon(input int g);
        int         t    = 0;
        int         per  = 16;
        int         nb   = 10;
        int         bt   = 0;
        bit         inf  = 0;
        bit         bad  = 0;
        bit         skip = 0;
        logic [7:0] e    = '0;
        logic       v;
        logic       ev;
        logic       bact = 1'b0;
        logic       bexp = 1'b0;
        forever begin
            @(negedge clk);
            v = get_tx(g);
            if (rst) begin
                inf = 0;
            end else begin
                if (!inf && v == 1'b0) begin
                    inf = 1;
                    t   = 0;
                    bad = 0;
                    per = 16 * (int'(br_div) + 1);
                    nb  = 1 + 8 + ((g != 0) ? 1 : 0) + (stop ? 2 : 1);
                    if (q_size(g) == 0) begin
                        skip = 1;
                        checks++;
                        failures++;
                        $display("FAIL frame_unexpected[%0d]: got a start bit, required idle line", g);
                    end else begin
                        skip = 0;
                        e    = q_pop(g);
                    end
                end
                if (inf) begin
                    ev = exp_bit(e, t, per, g);
                    if (!skip && !bad && v !== ev) begin
                        bad  = 1;
                        bt   = t;
                        bact = v;
                        bexp = ev;
                    end
                    if (t == nb * per - 1) begin
                        inf = 0;
                        if (!skip) begin
                            checks++;
                            if (bad) begin
                                failures++;
                                $display("FAIL frame[%0d] data=%02h: tx at frame cycle %0d got %0b required %0b",
                                         g, e, bt, bact, bexp);
                            end
                        end
                    end
                    t++;
                end
            end
        end
    endtask

    initial run_mon(0);
    initial run_mon(1);
    initial run_mon(2);

    initial begin
        int  nrand;
        bit  bbusy;
        bit  quiet[3];
        logic [7:0] d;

        rst     = 1'b1;
        en      = 1'b0;
        br_div  = 8'd0;
        stop    = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        for (int g = 0; g < 3; g++) mcnt[g] = 0;

        // Reset state
        repeat (3) tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_tx[%0d]", g), int'(get_tx(g)), 1);
            chk($sformatf("rst_busy[%0d]", g), int'(get_busy(g)), 0);
        end
        check_status("rst");
        rst = 1'b0;
        repeat (2) tick();

        // Single frames, one and two stop bits
        frame_len(8'h8E, 1'b0);
        frame_len(8'h8E, 1'b1);
        stop = 1'b0;

        // Push to empty is not popped that cycle; push during the pop edge keeps count
        en = 1'b1;
        push(8'hA5);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("push_empty_count[%0d]", g), get_cnt(g), 1);
            chk($sformatf("push_empty_busy[%0d]", g), int'(get_busy(g)), 0);
        end
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        for (int g = 0; g < 3; g++) q_push(g, 8'h3C);
        tick();
        wr_en = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("push_pop_count[%0d]", g), get_cnt(g), 1);
            chk($sformatf("push_pop_busy[%0d]", g), int'(get_busy(g)), 1);
        end
        drain("pushpop", 1'b1, 5000);

        // Fill with en=0, overflow drop, then back-to-back frames
        en = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(i));
        check_status("fill");
        en      = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h06;
        mcnt[0] = mcnt[0] - 1;
        for (int g = 1; g < 3; g++) q_push(g, 8'h06);
        tick();
        wr_en = 1'b0;
        check_status("full_push_pop");
        bbusy = 0;
        for (int k = 0; k < 640; k++) begin
            if (!busy0) bbusy = 1;
            if (k == 479) begin
                chk("b2b_count_before_last_pop", int'(cnt0), 1);
                chk("b2b_empty_before_last_pop", int'(empty0), 0);
            end
            if (k == 480) chk("b2b_empty_after_last_pop", int'(empty0), 1);
            tick();
        end
        chk("b2b_busy_gap", int'(bbusy), 0);
        chk("b2b_busy_end", int'(busy0), 0);
        drain("b2b", 1'b1, 10000);

        // Divisor change mid-frame only affects the following frame
        en     = 1'b0;
        br_div = 8'd8;
        push(8'h5A);
        push(8'hC3);
        en = 1'b1;
        repeat (500) tick();
        br_div = 8'd0;
        drain("brdiv", 1'b1, 10000);
        en = 1'b0;

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            en    = 1'b0;
            nrand = int'($urandom_range(1, 6));
            for (int i = 0; i < nrand; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                d = 8'($urandom);
                push(d);
            end
            check_status($sformatf("rnd%0d", r));
            br_div = 8'($urandom_range(0, 2));
            stop   = 1'($urandom_range(0, 1));
            en     = 1'b1;
            tick();
            drain($sformatf("rnd%0d", r), 1'b1, 30000);
        end
        en     = 1'b0;
        br_div = 8'd0;
        stop   = 1'b0;

        // en dropped mid-frame: current frame completes, no further pops
        push(8'h11);
        push(8'h22);
        push(8'h33);
        en = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) mcnt[g] = mcnt[g] - 1;
        repeat (40) tick();
        en = 1'b0;
        drain("endrop", 1'b0, 5000);
        for (int g = 0; g < 3; g++) quiet[g] = 1;
        for (int k = 0; k < 100; k++) begin
            for (int g = 0; g < 3; g++) begin
                if (get_busy(g) || !get_tx(g)) quiet[g] = 0;
            end
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("endrop_count[%0d]", g), get_cnt(g), 2);
            chk($sformatf("endrop_quiet[%0d]", g), int'(quiet[g]), 1);
        end

        // Reset mid-frame aborts the frame and discards the queue
        push(8'h44);
        en = 1'b1;
        tick();
        repeat (50) tick();
        rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("abort_tx[%0d]", g), int'(get_tx(g)), 1);
            chk($sformatf("abort_busy[%0d]", g), int'(get_busy(g)), 0);
            chk($sformatf("abort_count[%0d]", g), get_cnt(g), 0);
            chk($sformatf("abort_empty[%0d]", g), int'(get_empty(g)), 1);
            chk($sformatf("abort_full[%0d]", g), int'(get_full(g)), 0);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        for (int g = 0; g < 3; g++) mcnt[g] = 0;
        repeat (2) tick();
        rst = 1'b0;
        for (int g = 0; g < 3; g++) quiet[g] = 1;
        for (int k = 0; k < 300; k++) begin
            for (int g = 0; g < 3; g++) begin
                if (get_busy(g) || !get_tx(g)) quiet[g] = 0;
            end
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("post_rst_quiet[%0d]", g), int'(quiet[g]), 1);
        end
        push(8'h69);
        drain("post_rst", 1'b1, 5000);

        repeat (5) tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("frames_outstanding[%0d]", g), q_size(g), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
